// File: rtl/simpson_integrator_pkg.sv
// Shared definitions for the Simpson-rule cubic integrator.
//   W         operand (switch) width
//   RES_W     result width driven to the display block
//   ACC_W     internal arithmetic width, wide enough for (b-a)*F with no overflow
//   DIV_CONST divisor that turns (b-a)*F into the integral
//   state_t   operand-entry / compute FSM states
package simpson_pkg;
    localparam int W     = 16;
    localparam int RES_W = 16;
    localparam int ACC_W = 88;

    localparam int unsigned DIV_CONST = 48;

    typedef enum logic [2:0] {
        S_A0,
        S_A1,
        S_A2,
        S_A3,
        S_LA,
        S_LB,
        S_CALC,
        S_DONE
    } state_t;
endpackage

// File: rtl/simpson_integrator_if.sv
// Board-side bundle of the integrator: button and switches in, result and lamps out.
//   btn    debounced push-button level
//   sw     operand being entered
//   result integral, valid while led=1
//   led    result-valid indicator
//   err    error indicator
// master: board / testbench side; slave: integrator side.
interface simpson_integrator_if;
    import simpson_pkg::*;

    logic             btn;
    logic [W-1:0]     sw;
    logic [RES_W-1:0] result;
    logic             led;
    logic             err;

    modport master (output btn, output sw, input result, input led, input err);
    modport slave  (input btn, input sw, output result, output led, output err);
endinterface

// File: rtl/simpson_integrator_poly_eval8.sv
// Combinational evaluation of 8*f(x/2) for f(x) = a0 + a1*x + a2*x^2 + a3*x^3,
// taking x2 = 2*x so that midpoint evaluation stays integer-exact.
//   a0..a3 polynomial coefficients (W bits)
//   x2     twice the evaluation point (ACC_W bits)
//   f8     8*f(x2/2) = 8*a0 + 4*a1*x2 + 2*a2*x2^2 + a3*x2^3
module poly_eval8
    import simpson_pkg::*;
(
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     a2,
    input  logic [W-1:0]     a3,
    input  logic [ACC_W-1:0] x2,
    output logic [ACC_W-1:0] f8
);
    logic [ACC_W-1:0] x2_sq;
    logic [ACC_W-1:0] x2_cu;

    assign x2_sq = x2 * x2;
    assign x2_cu = x2_sq * x2;

    assign f8 = (ACC_W'(a0) << 3)
              + ((ACC_W'(a1) * x2) << 2)
              + ((ACC_W'(a2) * x2_sq) << 1)
              + (ACC_W'(a3) * x2_cu);
endmodule

// File: rtl/simpson_integrator.sv
// Button-driven Simpson-rule integrator of a cubic over [a, b].
// Six operands (a0, a1, a2, a3, a, b) are latched from sw on successive button
// presses, then a short sequenced computation produces floor(integral).
//   clk       system clock
//   cpu_reset synchronous active-high reset, aborts any operation
//   bus       slave side of simpson_integrator_if (btn, sw, result, led, err)
//
// state  | meaning
// S_A0   | waiting for a0 (also the idle state after reset)
// S_A1   | waiting for a1
// S_A2   | waiting for a2
// S_A3   | waiting for a3
// S_LA   | waiting for lower limit a
// S_LB   | waiting for upper limit b
// S_CALC | accumulating F over three evaluations, then scaling and dividing
// S_DONE | result shown; next press starts a new run with sw as a0
module simpson_integrator
    import simpson_pkg::*;
(
    input logic               clk,
    input logic               cpu_reset,
    simpson_integrator_if.slave bus
);
    state_t state_q, state_d;

    logic             btn_q;
    logic             press;
    logic [W-1:0]     a0_r, a1_r, a2_r, a3_r, a_r, b_r;
    logic [1:0]       calc_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] x2_sel;
    logic [ACC_W-1:0] f8;
    logic [ACC_W-1:0] n_prod;
    logic [ACC_W-1:0] quot;
    logic [RES_W-1:0] result_r;
    logic             led_r;
    logic             err_r;

    assign press = bus.btn & ~btn_q;

    // calc_cnt counts down 3 -> 0: f(a), f(midpoint) x4, f(b), then finalize.
    always_comb begin
        x2_sel = ACC_W'({b_r, 1'b0});
        case (calc_cnt)
            2'd3:    x2_sel = ACC_W'({a_r, 1'b0});
            2'd2:    x2_sel = ACC_W'(a_r) + ACC_W'(b_r);
            default: x2_sel = ACC_W'({b_r, 1'b0});
        endcase
    end

    poly_eval8 u_poly (
        .a0 (a0_r),
        .a1 (a1_r),
        .a2 (a2_r),
        .a3 (a3_r),
        .x2 (x2_sel),
        .f8 (f8)
    );

    // Only meaningful when a <= b; the a > b case is flagged before it is used.
    assign n_prod = (ACC_W'(b_r) - ACC_W'(a_r)) * acc;
    assign quot   = n_prod / ACC_W'(DIV_CONST);

    always_ff @(posedge clk) begin
        btn_q <= bus.btn;
        if (cpu_reset) state_q <= S_A0;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A0:    if (press) state_d = S_A1;
            S_A1:    if (press) state_d = S_A2;
            S_A2:    if (press) state_d = S_A3;
            S_A3:    if (press) state_d = S_LA;
            S_LA:    if (press) state_d = S_LB;
            S_LB:    if (press) state_d = S_CALC;
            S_CALC:  if (calc_cnt == 2'd0) state_d = S_DONE;
            S_DONE:  if (press) state_d = S_A1;
            default: state_d = S_A0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpu_reset) begin
            a0_r     <= '0;
            a1_r     <= '0;
            a2_r     <= '0;
            a3_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            calc_cnt <= '0;
            result_r <= '0;
            led_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case (state_q)
                S_A0: if (press) a0_r <= bus.sw;
                S_A1: if (press) a1_r <= bus.sw;
                S_A2: if (press) a2_r <= bus.sw;
                S_A3: if (press) a3_r <= bus.sw;
                S_LA: if (press) a_r  <= bus.sw;
                S_LB: if (press) begin
                    b_r      <= bus.sw;
                    acc      <= '0;
                    calc_cnt <= 2'd3;
                end
                S_CALC: begin
                    case (calc_cnt)
                        2'd3: acc <= acc + f8;
                        2'd2: acc <= acc + (f8 << 2);
                        2'd1: acc <= acc + f8;
                        default: begin
                            led_r <= 1'b1;
                            if (a_r > b_r) begin
                                err_r    <= 1'b1;
                                result_r <= '0;
                            end else if (|quot[ACC_W-1:RES_W]) begin
                                err_r    <= 1'b1;
                                result_r <= '1;
                            end else begin
                                err_r    <= 1'b0;
                                result_r <= quot[RES_W-1:0];
                            end
                        end
                    endcase
                    if (calc_cnt != 2'd0) calc_cnt <= calc_cnt - 2'd1;
                end
                S_DONE: if (press) begin
                    a0_r     <= bus.sw;
                    led_r    <= 1'b0;
                    err_r    <= 1'b0;
                    result_r <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.led    = led_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_simpson_integrator.sv
module tb_simpson_integrator;
    typedef logic [15:0] ops_t [6];

    logic clk = 1'b0;
    logic cpu_reset;
    int   vectors = 0;
    int   miscompares = 0;

    simpson_integrator_if ifc ();

    simpson_integrator dut (
        .clk       (clk),
        .cpu_reset (cpu_reset),
        .bus       (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: 12*integral from the antiderivative, then floor(/12).
    task automatic model(input ops_t op, output logic [15:0] r, output logic e);
        logic [127:0] c0, c1, c2, c3, la, lb, t, q;
        c0 = 128'(op[0]); c1 = 128'(op[1]); c2 = 128'(op[2]); c3 = 128'(op[3]);
        la = 128'(op[4]); lb = 128'(op[5]);
        if (la > lb) begin
            r = 16'd0; e = 1'b1;
        end else begin
            t = 128'd12 * c0 * (lb - la)
              + 128'd6 * c1 * (lb*lb - la*la)
              + 128'd4 * c2 * (lb*lb*lb - la*la*la)
              + 128'd3 * c3 * (lb*lb*lb*lb - la*la*la*la);
            q = t / 128'd12;
            if (q > 128'd65535) begin r = 16'hFFFF; e = 1'b1; end
            else begin r = q[15:0]; e = 1'b0; end
        end
    endtask

    task automatic press(input logic [15:0] val);
        @(negedge clk); ifc.sw = val; ifc.btn = 1'b1;
        @(negedge clk); ifc.btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); cpu_reset = 1'b1;
        @(negedge clk);
        @(negedge clk); cpu_reset = 1'b0;
        check("rst_result", 128'(ifc.result), 0);
        check("rst_led", 128'(ifc.led), 0);
        check("rst_err", 128'(ifc.err), 0);
    endtask

    task automatic do_run(input string tag, input ops_t op, input int hold, input bit chk_drop,
                          input logic [15:0] exp_r, input logic exp_e);
        int  cycles;
        bit  done;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); ifc.sw = op[i]; ifc.btn = 1'b1;
            repeat ((i == 0) ? hold : 1) @(negedge clk);
            ifc.btn = 1'b0;
            if (i == 0 && chk_drop) check({tag, "_led_drop"}, 128'(ifc.led), 0);
            @(negedge clk);
        end
        @(negedge clk); ifc.sw = op[5]; ifc.btn = 1'b1;
        cycles = 0; done = 1'b0;
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            ifc.btn = 1'b0;
            cycles++;
            if (ifc.led) done = 1'b1;
        end
        check({tag, "_timeout"}, 128'(done), 1);
        check({tag, "_latency_le16"}, 128'((cycles - 1) <= 16), 1);
        @(negedge clk);
        check({tag, "_result"}, 128'(ifc.result), 128'(exp_r));
        check({tag, "_err"}, 128'(ifc.err), 128'(exp_e));
        check({tag, "_led"}, 128'(ifc.led), 1);
    endtask

    initial begin
        ops_t        op;
        logic [15:0] er;
        logic        ee;

        ifc.btn = 1'b0; ifc.sw = '0; cpu_reset = 1'b1;
        repeat (3) @(negedge clk);
        cpu_reset = 1'b0;
        check("reset_result", 128'(ifc.result), 0);
        check("reset_led", 128'(ifc.led), 0);
        check("reset_err", 128'(ifc.err), 0);

        op = '{16'd7, 16'd0, 16'd0, 16'd0, 16'd7, 16'd15};
        do_run("run1", op, 1, 1'b0, 16'd56, 1'b0);
        op = '{16'd1, 16'd3, 16'd0, 16'd0, 16'd2, 16'd8};
        do_run("run2", op, 1, 1'b1, 16'd96, 1'b0);
        op = '{16'd4, 16'd2, 16'd1, 16'd0, 16'd1, 16'd6};
        do_run("run3", op, 1, 1'b1, 16'd126, 1'b0);
        op = '{16'd1, 16'd1, 16'd2, 16'd1, 16'd2, 16'd5};
        do_run("run4", op, 1, 1'b1, 16'd243, 1'b0);
        op = '{16'd4, 16'd10, 16'd0, 16'd2, 16'd5, 16'd12};
        do_run("frac", op, 1, 1'b1, 16'd10678, 1'b0);
        op = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd5, 16'd4};
        do_run("a_gt_b", op, 1, 1'b1, 16'd0, 1'b1);
        do_reset();

        op = '{16'd3, 16'd1, 16'd0, 16'd0, 16'd0, 16'd10};
        do_run("hold14", op, 14, 1'b0, 16'd80, 1'b0);

        do_reset();
        press(16'd9); press(16'd9); press(16'd9);
        do_reset();
        op = '{16'd2, 16'd0, 16'd3, 16'd0, 16'd1, 16'd4};
        do_run("after_midreset", op, 1, 1'b0, 16'd69, 1'b0);

        op = '{16'd0, 16'd0, 16'd0, 16'd65535, 16'd0, 16'd100};
        do_run("saturate", op, 1, 1'b1, 16'hFFFF, 1'b1);

        op = '{16'd9, 16'd9, 16'd9, 16'd9, 16'd3, 16'd3};
        do_run("a_eq_b", op, 1, 1'b1, 16'd0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                for (int j = 0; j < 4; j++) op[j] = 16'($urandom_range(0, 50));
                op[4] = 16'($urandom_range(0, 200));
                op[5] = 16'($urandom_range(0, 200));
            end else begin
                for (int j = 0; j < 6; j++) op[j] = 16'($urandom_range(0, 65535));
            end
            model(op, er, ee);
            do_run($sformatf("rand%0d", k), op, 1 + (k % 3), 1'b1, er, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
